// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter: shares the single dtcm_ctrl port between the LSU (port 0)
// and the external/debug master (port 1). Commands are granted round-robin
// and a grant is held until its command handshakes. Every accepted command
// leaves its port id in a small FIFO so responses, which come back in
// order, are steered to the requester that issued them.
module dtcm_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter int OUTS_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,

   // LSU (port 0)
   input  logic                lsu_cmd_valid,
   output logic                lsu_cmd_ready,
   input  logic                lsu_cmd_read,
   input  logic [AW-1:0]       lsu_cmd_addr,
   input  logic [DW-1:0]       lsu_cmd_wdata,
   input  logic [DW/8-1:0]     lsu_cmd_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DW-1:0]       lsu_rsp_rdata,

   // external / debug master (port 1)
   input  logic                ext_cmd_valid,
   output logic                ext_cmd_ready,
   input  logic                ext_cmd_read,
   input  logic [AW-1:0]       ext_cmd_addr,
   input  logic [DW-1:0]       ext_cmd_wdata,
   input  logic [DW/8-1:0]     ext_cmd_wmask,
   output logic                ext_rsp_valid,
   input  logic                ext_rsp_ready,
   output logic [DW-1:0]       ext_rsp_rdata,

   // dtcm_ctrl side
   output logic                dtcm_cmd_valid,
   input  logic                dtcm_cmd_ready,
   output logic                dtcm_cmd_read,
   output logic [AW-1:0]       dtcm_cmd_addr,
   output logic [DW-1:0]       dtcm_cmd_wdata,
   output logic [DW/8-1:0]     dtcm_cmd_wmask,
   input  logic                dtcm_rsp_valid,
   output logic                dtcm_rsp_ready,
   input  logic [DW-1:0]       dtcm_rsp_rdata
);

   // Pointer width is kept at least one bit so OUTS_DEPTH=1 still elaborates.
   localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int CW = $clog2(OUTS_DEPTH + 1);

   localparam logic [PW-1:0] PTR_LAST  = PW'(OUTS_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(OUTS_DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   // rr_ptr_q holds the last winner; rr_seen_q says whether any winner has
   // been recorded since reset, so the very first contest favours the LSU.
   logic            rr_ptr_q,  rr_ptr_d;
   logic            rr_seen_q, rr_seen_d;
   logic            lock_q,    lock_d;
   logic            lock_id_q, lock_id_d;
   logic [PW-1:0]   wr_ptr_q,  wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q,  rd_ptr_d;
   logic [CW-1:0]   count_q,   count_d;
   logic            id_mem_q [OUTS_DEPTH];

   // ------------------------------------------------------------------
   // Command side
   // ------------------------------------------------------------------
   logic gnt_id;
   logic gnt_valid;
   logic full;
   logic cmd_hs;

   // Pick the granted port: a locked grant wins outright, otherwise
   // round-robin against the last winner.
   always_comb begin
      gnt_id = 1'b0;
      if (lock_q) begin
         gnt_id = lock_id_q;
      end else if (lsu_cmd_valid && ext_cmd_valid) begin
         gnt_id = rr_seen_q ? ~rr_ptr_q : 1'b0;
      end else if (ext_cmd_valid) begin
         gnt_id = 1'b1;
      end else begin
         gnt_id = 1'b0;
      end
   end

   assign gnt_valid = gnt_id ? ext_cmd_valid : lsu_cmd_valid;

   // full looks only at the registered count: a pop in the same cycle does
   // not free a slot for a push until the next cycle.
   assign full = (count_q == CNT_FULL);

   assign dtcm_cmd_valid = gnt_valid & ~full;
   assign cmd_hs         = dtcm_cmd_valid & dtcm_cmd_ready;

   assign lsu_cmd_ready  = gnt_valid & ~gnt_id & dtcm_cmd_ready & ~full;
   assign ext_cmd_ready  = gnt_valid &  gnt_id & dtcm_cmd_ready & ~full;

   // Steer the granted command fields; drive zeros when nobody is asking.
   always_comb begin
      dtcm_cmd_read  = 1'b0;
      dtcm_cmd_addr  = '0;
      dtcm_cmd_wdata = '0;
      dtcm_cmd_wmask = '0;
      if (gnt_valid) begin
         if (gnt_id) begin
            dtcm_cmd_read  = ext_cmd_read;
            dtcm_cmd_addr  = ext_cmd_addr;
            dtcm_cmd_wdata = ext_cmd_wdata;
            dtcm_cmd_wmask = ext_cmd_wmask;
         end else begin
            dtcm_cmd_read  = lsu_cmd_read;
            dtcm_cmd_addr  = lsu_cmd_addr;
            dtcm_cmd_wdata = lsu_cmd_wdata;
            dtcm_cmd_wmask = lsu_cmd_wmask;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response side
   // ------------------------------------------------------------------
   logic fifo_empty;
   logic head_id;
   logic head_lsu;
   logic head_ext;
   logic rsp_hs;

   assign fifo_empty = (count_q == '0);
   assign head_id    = id_mem_q[rd_ptr_q];
   assign head_lsu   = ~fifo_empty & ~head_id;
   assign head_ext   = ~fifo_empty &  head_id;

   assign lsu_rsp_valid  = head_lsu & dtcm_rsp_valid;
   assign ext_rsp_valid  = head_ext & dtcm_rsp_valid;
   assign lsu_rsp_rdata  = head_lsu ? dtcm_rsp_rdata : '0;
   assign ext_rsp_rdata  = head_ext ? dtcm_rsp_rdata : '0;

   // With nothing outstanding the response port is never ready, so a stray
   // dtcm response is simply ignored.
   assign dtcm_rsp_ready = (head_lsu & lsu_rsp_ready) | (head_ext & ext_rsp_ready);
   assign rsp_hs         = dtcm_rsp_valid & dtcm_rsp_ready;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // Arbitration state: remember the winner and pin a stalled grant.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      rr_seen_d = rr_seen_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (cmd_hs) begin
         rr_ptr_d  = gnt_id;
         rr_seen_d = 1'b1;
         lock_d    = 1'b0;
      end else if (dtcm_cmd_valid) begin
         lock_d    = 1'b1;
         lock_id_d = gnt_id;
      end
   end

   // Outstanding-ID FIFO bookkeeping; pointers wrap at OUTS_DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (cmd_hs) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rsp_hs) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      if (cmd_hs && !rsp_hs) begin
         count_d = count_q + CW'(1);
      end else if (!cmd_hs && rsp_hs) begin
         count_d = count_q - CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // Arbitration and lock registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= 1'b0;
         rr_seen_q <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         rr_seen_q <= rr_seen_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   // FIFO pointers and outstanding count; reset drops all outstanding IDs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ID storage needs no reset: entries are only read while count_q > 0.
   always_ff @(posedge clk) begin
      if (cmd_hs) begin
         id_mem_q[wr_ptr_q] <= gnt_id;
      end
   end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed testbench for dtcm_arbiter. The bench plays dtcm_ctrl: each
// accepted command pushes {port id, response data} onto a scoreboard queue,
// and each response the bench returns is checked against the queue head.
module tb_dtcm_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;

   logic            lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
   logic [AW-1:0]   lsu_cmd_addr;
   logic [DW-1:0]   lsu_cmd_wdata;
   logic [DW/8-1:0] lsu_cmd_wmask;
   logic            lsu_rsp_valid, lsu_rsp_ready;
   logic [DW-1:0]   lsu_rsp_rdata;

   logic            ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
   logic [AW-1:0]   ext_cmd_addr;
   logic [DW-1:0]   ext_cmd_wdata;
   logic [DW/8-1:0] ext_cmd_wmask;
   logic            ext_rsp_valid, ext_rsp_ready;
   logic [DW-1:0]   ext_rsp_rdata;

   logic            dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
   logic [AW-1:0]   dtcm_cmd_addr;
   logic [DW-1:0]   dtcm_cmd_wdata;
   logic [DW/8-1:0] dtcm_cmd_wmask;
   logic            dtcm_rsp_valid, dtcm_rsp_ready;
   logic [DW-1:0]   dtcm_rsp_rdata;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // scoreboard entry: {port id, response data}
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   dtcm_arbiter #(.AW(AW), .DW(DW), .OUTS_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lsu_cmd_valid  (lsu_cmd_valid),
      .lsu_cmd_ready  (lsu_cmd_ready),
      .lsu_cmd_read   (lsu_cmd_read),
      .lsu_cmd_addr   (lsu_cmd_addr),
      .lsu_cmd_wdata  (lsu_cmd_wdata),
      .lsu_cmd_wmask  (lsu_cmd_wmask),
      .lsu_rsp_valid  (lsu_rsp_valid),
      .lsu_rsp_ready  (lsu_rsp_ready),
      .lsu_rsp_rdata  (lsu_rsp_rdata),
      .ext_cmd_valid  (ext_cmd_valid),
      .ext_cmd_ready  (ext_cmd_ready),
      .ext_cmd_read   (ext_cmd_read),
      .ext_cmd_addr   (ext_cmd_addr),
      .ext_cmd_wdata  (ext_cmd_wdata),
      .ext_cmd_wmask  (ext_cmd_wmask),
      .ext_rsp_valid  (ext_rsp_valid),
      .ext_rsp_ready  (ext_rsp_ready),
      .ext_rsp_rdata  (ext_rsp_rdata),
      .dtcm_cmd_valid (dtcm_cmd_valid),
      .dtcm_cmd_ready (dtcm_cmd_ready),
      .dtcm_cmd_read  (dtcm_cmd_read),
      .dtcm_cmd_addr  (dtcm_cmd_addr),
      .dtcm_cmd_wdata (dtcm_cmd_wdata),
      .dtcm_cmd_wmask (dtcm_cmd_wmask),
      .dtcm_rsp_valid (dtcm_rsp_valid),
      .dtcm_rsp_ready (dtcm_rsp_ready),
      .dtcm_rsp_rdata (dtcm_rsp_rdata)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      lsu_cmd_valid  = 1'b0; lsu_cmd_read = 1'b0; lsu_cmd_addr = '0;
      lsu_cmd_wdata  = '0;   lsu_cmd_wmask = '0;  lsu_rsp_ready = 1'b0;
      ext_cmd_valid  = 1'b0; ext_cmd_read = 1'b0; ext_cmd_addr = '0;
      ext_cmd_wdata  = '0;   ext_cmd_wmask = '0;  ext_rsp_ready = 1'b0;
      dtcm_cmd_ready = 1'b0; dtcm_rsp_valid = 1'b0; dtcm_rsp_rdata = '0;
   endtask

   task automatic chk_cmd(input string tag, input logic exp_valid, input logic exp_lrdy,
                          input logic exp_erdy, input logic [15:0] exp_addr);
      chk1({tag, ".dtcm_cmd_valid"}, dtcm_cmd_valid, exp_valid);
      chk1({tag, ".lsu_cmd_ready"},  lsu_cmd_ready,  exp_lrdy);
      chk1({tag, ".ext_cmd_ready"},  ext_cmd_ready,  exp_erdy);
      chkw({tag, ".dtcm_cmd_addr"},  {16'h0, dtcm_cmd_addr}, {16'h0, exp_addr});
   endtask

   // Checks the response currently presented for the scoreboard head,
   // assuming both requesters are ready.
   task automatic chk_rsp_head(input string tag);
      logic        id;
      logic [31:0] data;
      if (sb.size() == 0) begin
         total_cnt++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
         return;
      end
      id   = sb[0][32];
      data = sb[0][31:0];
      chk1({tag, ".lsu_rsp_valid"},  lsu_rsp_valid, ~id);
      chk1({tag, ".ext_rsp_valid"},  ext_rsp_valid, id);
      chkw({tag, ".rsp_rdata"},      id ? ext_rsp_rdata : lsu_rsp_rdata, data);
      chk1({tag, ".dtcm_rsp_ready"}, dtcm_rsp_ready, 1'b1);
   endtask

   task automatic drain_one(input string tag);
      if (sb.size() == 0) begin
         total_cnt++;
         $error("FAIL %s nothing outstanding observed=0 expected=1", tag);
         return;
      end
      lsu_rsp_ready  = 1'b1;
      ext_rsp_ready  = 1'b1;
      dtcm_rsp_valid = 1'b1;
      dtcm_rsp_rdata = sb[0][31:0];
      settle();
      chk_rsp_head(tag);
      step();
      void'(sb.pop_front());
      dtcm_rsp_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      sb.delete();
      step();
   endtask

   // safety net so the run can never hang
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic had_rsp;
      logic g;
      logic [15:0] ga;

      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // reset state, inputs idle
      chk1("rst.lsu_cmd_ready",  lsu_cmd_ready,  1'b0);
      chk1("rst.ext_cmd_ready",  ext_cmd_ready,  1'b0);
      chk1("rst.dtcm_cmd_valid", dtcm_cmd_valid, 1'b0);
      chk1("rst.dtcm_rsp_ready", dtcm_rsp_ready, 1'b0);
      chk1("rst.lsu_rsp_valid",  lsu_rsp_valid,  1'b0);
      chk1("rst.ext_rsp_valid",  ext_rsp_valid,  1'b0);
      chkw("rst.dtcm_cmd_addr",  {16'h0, dtcm_cmd_addr}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // T1: LSU-only read, response one cycle later
      lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0010;
      dtcm_cmd_ready = 1'b1;
      settle();
      chk_cmd("t1.cmd", 1'b1, 1'b1, 1'b0, 16'h0010);
      chk1("t1.dtcm_cmd_read", dtcm_cmd_read, 1'b1);
      sb.push_back({1'b0, 32'hDEADBEEF});
      step();
      lsu_cmd_valid = 1'b0; dtcm_cmd_ready = 1'b0;
      drain_one("t1.rsp");

      // T2: both valid every cycle, grants alternate starting with LSU,
      // responses looped back one cycle after each command
      idle();
      do_reset();
      lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1;
      ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1;
      lsu_rsp_ready = 1'b1; ext_rsp_ready = 1'b1;
      dtcm_cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lsu_cmd_addr = 16'h0100 + 16'(i);
         ext_cmd_addr = 16'h0200 + 16'(i);
         had_rsp = (sb.size() > 0);
         dtcm_rsp_valid = had_rsp;
         dtcm_rsp_rdata = had_rsp ? sb[0][31:0] : 32'h0;
         settle();
         g  = (i % 2) == 1;
         ga = g ? ext_cmd_addr : lsu_cmd_addr;
         chk_cmd($sformatf("t2.cmd%0d", i), 1'b1, ~g, g, ga);
         if (had_rsp) chk_rsp_head($sformatf("t2.rsp%0d", i));
         step();
         if (had_rsp) void'(sb.pop_front());
         sb.push_back({g, 16'hC0DE, ga});
      end
      lsu_cmd_valid = 1'b0; ext_cmd_valid = 1'b0; dtcm_cmd_ready = 1'b0;
      drain_one("t2.rsp_last");

      // T3: ext stalls with dtcm_cmd_ready=0; the grant stays with ext even
      // when LSU joins (round-robin alone would now pick LSU)
      ext_cmd_valid = 1'b1; ext_cmd_read = 1'b0; ext_cmd_addr = 16'h0300;
      ext_cmd_wdata = 32'h12345678; ext_cmd_wmask = 4'b0110;
      settle();
      chk_cmd("t3.ext_alone", 1'b1, 1'b0, 1'b0, 16'h0300);
      chk1("t3.dtcm_cmd_read",  dtcm_cmd_read, 1'b0);
      chkw("t3.dtcm_cmd_wdata", dtcm_cmd_wdata, 32'h12345678);
      chkw("t3.dtcm_cmd_wmask", {28'h0, dtcm_cmd_wmask}, 32'h6);
      step();
      lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0400;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk_cmd($sformatf("t3.hold%0d", k), 1'b1, 1'b0, 1'b0, 16'h0300);
         step();
      end
      dtcm_cmd_ready = 1'b1;
      settle();
      chk_cmd("t3.ext_go", 1'b1, 1'b0, 1'b1, 16'h0300);
      sb.push_back({1'b1, 32'hACC00300});
      step();
      ext_cmd_valid = 1'b0;
      settle();
      chk_cmd("t3.lsu_next", 1'b1, 1'b1, 1'b0, 16'h0400);
      sb.push_back({1'b0, 32'h11110400});
      step();

      // T4: two outstanding -> third request blocked, even with a pop in
      // the same cycle; it issues on the following cycle
      lsu_cmd_addr = 16'h0500;
      settle();
      chk_cmd("t4.full", 1'b0, 1'b0, 1'b0, 16'h0500);
      step();
      lsu_rsp_ready = 1'b1; ext_rsp_ready = 1'b1;
      dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = sb[0][31:0];
      settle();
      chk_cmd("t4.full_pop", 1'b0, 1'b0, 1'b0, 16'h0500);
      chk_rsp_head("t4.rsp");
      step();
      void'(sb.pop_front());
      dtcm_rsp_valid = 1'b0;
      settle();
      chk_cmd("t4.issue", 1'b1, 1'b1, 1'b0, 16'h0500);
      sb.push_back({1'b0, 32'h22220500});
      step();
      lsu_cmd_valid = 1'b0;

      // T5: response backpressure on the LSU head
      dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = sb[0][31:0];
      lsu_rsp_ready = 1'b0; ext_rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk1($sformatf("t5.bp%0d.lsu_rsp_valid", k),  lsu_rsp_valid,  1'b1);
         chk1($sformatf("t5.bp%0d.ext_rsp_valid", k),  ext_rsp_valid,  1'b0);
         chk1($sformatf("t5.bp%0d.dtcm_rsp_ready", k), dtcm_rsp_ready, 1'b0);
         chkw($sformatf("t5.bp%0d.lsu_rsp_rdata", k),  lsu_rsp_rdata,  sb[0][31:0]);
         step();
      end
      lsu_rsp_ready = 1'b1;
      settle();
      chk_rsp_head("t5.release");
      step();
      void'(sb.pop_front());
      dtcm_rsp_valid = 1'b0;
      // one outstanding left: exactly one more command fits
      ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 16'h0600;
      settle();
      chk_cmd("t5.ext", 1'b1, 1'b0, 1'b1, 16'h0600);
      sb.push_back({1'b1, 32'h33330600});
      step();
      ext_cmd_valid = 1'b0;
      lsu_cmd_valid = 1'b1; lsu_cmd_addr = 16'h0700;
      settle();
      chk_cmd("t5.full_again", 1'b0, 1'b0, 1'b0, 16'h0700);
      step();
      lsu_cmd_valid = 1'b0;

      // T6: reset with two outstanding, then a stray dtcm response
      do_reset();
      lsu_rsp_ready = 1'b1; ext_rsp_ready = 1'b1;
      dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'hBAD0BAD0;
      settle();
      chk1("t6.lsu_rsp_valid",  lsu_rsp_valid,  1'b0);
      chk1("t6.ext_rsp_valid",  ext_rsp_valid,  1'b0);
      chk1("t6.dtcm_rsp_ready", dtcm_rsp_ready, 1'b0);
      step();
      dtcm_rsp_valid = 1'b0;
      // count is 0: two commands fit, first contest favours LSU
      lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0800;
      ext_cmd_valid = 1'b1; ext_cmd_read = 1'b1; ext_cmd_addr = 16'h0900;
      dtcm_cmd_ready = 1'b1;
      settle();
      chk_cmd("t6.favour_lsu", 1'b1, 1'b1, 1'b0, 16'h0800);
      sb.push_back({1'b0, 32'h44440800});
      step();
      lsu_cmd_valid = 1'b0;
      settle();
      chk_cmd("t6.ext", 1'b1, 1'b0, 1'b1, 16'h0900);
      sb.push_back({1'b1, 32'h55550900});
      step();
      ext_cmd_valid = 1'b0;
      lsu_cmd_valid = 1'b1; lsu_cmd_addr = 16'h0A00;
      settle();
      chk_cmd("t6.full", 1'b0, 1'b0, 1'b0, 16'h0A00);
      step();
      lsu_cmd_valid = 1'b0; dtcm_cmd_ready = 1'b0;
      drain_one("t6.rsp0");
      drain_one("t6.rsp1");

      // back to idle
      settle();
      chk1("end.dtcm_cmd_valid", dtcm_cmd_valid, 1'b0);
      chk1("end.dtcm_rsp_ready", dtcm_rsp_ready, 1'b0);
      chkw("end.outstanding", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
